// File: rtl/boron_pkg.sv
// Shared types, constants and S-box helpers for the boron block cipher core.
package boron_pkg;

  typedef enum logic [1:0] {
    IDLE,
    KEY_FWD,
    ROUND,
    DONE
  } state_e;

  localparam int unsigned BLOCK_W   = 64;
  localparam int unsigned KEY_W_80  = 80;
  localparam int unsigned KEY_W_128 = 128;

  // Nibble i of each table sits at bits [4*i+3:4*i].
  localparam logic [63:0] SBOX_TBL     = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] SBOX_INV_TBL = 64'hA970_364B_D21C_8FE5;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sbox4_inv(input logic [3:0] x);
    return SBOX_INV_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic key_w_legal(input int unsigned w);
    return (w == KEY_W_80) || (w == KEY_W_128);
  endfunction

endpackage

// File: rtl/boron_crypt_core_if.sv
// Request/response bundle between a client and boron_crypt_core.
interface boron_crypt_core_if #(
  parameter int unsigned KEY_W = 80
);
  import boron_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic               mode;
  logic [KEY_W-1:0]   key;
  logic [BLOCK_W-1:0] data_in;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] data_out;
  logic               busy;

  modport master (
    output in_valid, mode, key, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, mode, key, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );

endinterface

// File: rtl/boron_key_step.sv
// One step of the key schedule, forward or backward, for a given round index.
module boron_key_step
  import boron_pkg::*;
#(
  parameter int unsigned KEY_W = 80
) (
  input  logic [KEY_W-1:0] key_i,
  input  logic [4:0]       round_i,
  input  logic             inverse_i,
  output logic [KEY_W-1:0] key_o
);

  logic [4:0]       rc;
  logic [KEY_W-1:0] fwd_t;
  logic [KEY_W-1:0] inv_t;

  // Forward: rotate left 13, S-box low nibble, fold round constant; backward undoes it in reverse order.
  always_comb begin
    rc          = round_i + 5'd1;
    fwd_t       = {key_i[KEY_W-14:0], key_i[KEY_W-1:KEY_W-13]};
    fwd_t[3:0]  = sbox4(fwd_t[3:0]);
    fwd_t[63:59] = fwd_t[63:59] ^ rc;
    inv_t       = key_i;
    inv_t[63:59] = inv_t[63:59] ^ rc;
    inv_t[3:0]  = sbox4_inv(inv_t[3:0]);
    key_o       = inverse_i ? {inv_t[12:0], inv_t[KEY_W-1:13]} : fwd_t;
  end

endmodule

// File: rtl/boron_crypt_core.sv
// Iterative 64-bit block cipher core: one round per cycle, with a one-entry
// cache of the last round key so repeated decrypts skip the forward schedule.
module boron_crypt_core
  import boron_pkg::*;
#(
  parameter int unsigned KEY_W  = 80,
  parameter int unsigned ROUNDS = 25
) (
  input logic               clk,
  input logic               reset,
  boron_crypt_core_if.slave bus
);

  if (!key_w_legal(KEY_W)) begin : g_bad_key_w
    $error("boron_crypt_core: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("boron_crypt_core: ROUNDS must be 1..31");
  end

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int unsigned n);
    return (x << n) | (x >> (16 - n));
  endfunction

  function automatic logic [63:0] sub_layer(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      y[4*i +: 4] = inv ? sbox4_inv(x[4*i +: 4]) : sbox4(x[4*i +: 4]);
    end
    return y;
  endfunction

  function automatic logic [63:0] shuffle(input logic [63:0] x);
    return {rotl16(x[63:48], 9), rotl16(x[47:32], 7), rotl16(x[31:16], 1), x[15:0]};
  endfunction

  function automatic logic [63:0] unshuffle(input logic [63:0] x);
    return {rotl16(x[63:48], 7), rotl16(x[47:32], 9), rotl16(x[31:16], 15), x[15:0]};
  endfunction

  function automatic logic [63:0] mix(input logic [63:0] x);
    return {x[63:48], x[47:32] ^ x[63:48], x[31:16] ^ x[47:32], x[15:0] ^ x[31:16]};
  endfunction

  function automatic logic [63:0] unmix(input logic [63:0] y);
    logic [15:0] w3, w2, w1, w0;
    w3 = y[63:48];
    w2 = y[47:32] ^ w3;
    w1 = y[31:16] ^ w2;
    w0 = y[15:0] ^ w1;
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [63:0] round_fwd(input logic [63:0] x);
    return mix(shuffle(sub_layer(x, 1'b0)));
  endfunction

  function automatic logic [63:0] round_inv(input logic [63:0] x);
    return sub_layer(unshuffle(unmix(x)), 1'b1);
  endfunction

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] orig_key_q, orig_key_d;
  logic [KEY_W-1:0] cache_key_q, cache_key_d;
  logic [KEY_W-1:0] cache_last_q, cache_last_d;
  logic             cache_valid_q, cache_valid_d;
  logic [63:0]      blk_q, blk_d;
  logic [63:0]      data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;

  logic [KEY_W-1:0] ks_key;
  logic [63:0]      rk_cur, rk_next, enc_blk, dec_blk;

  boron_key_step #(.KEY_W(KEY_W)) u_key_step (
    .key_i    (key_q),
    .round_i  (cnt_q),
    .inverse_i((state_q == ROUND) && dec_q),
    .key_o    (ks_key)
  );

  assign rk_cur  = key_q[KEY_W-1 -: 64];
  assign rk_next = ks_key[KEY_W-1 -: 64];
  // Whitening is folded into the boundary round: after the last encrypt round, before the first decrypt round.
  assign enc_blk = round_fwd(blk_q ^ rk_cur) ^ ((cnt_q == LAST) ? rk_next : 64'h0);
  assign dec_blk = round_inv(blk_q ^ ((cnt_q == LAST) ? rk_cur : 64'h0)) ^ rk_next;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;

  // Next-state, datapath and cache update logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dec_d         = dec_q;
    key_d         = key_q;
    orig_key_d    = orig_key_q;
    cache_key_d   = cache_key_q;
    cache_last_d  = cache_last_q;
    cache_valid_d = cache_valid_q;
    blk_d         = blk_q;
    data_out_d    = data_out_q;
    out_valid_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          dec_d      = bus.mode;
          orig_key_d = bus.key;
          blk_d      = bus.data_in;
          if (!bus.mode) begin
            state_d = ROUND;
            cnt_d   = '0;
            key_d   = bus.key;
          end else if (cache_valid_q && (bus.key == cache_key_q)) begin
            state_d = ROUND;
            cnt_d   = LAST;
            key_d   = cache_last_q;
          end else begin
            state_d = KEY_FWD;
            cnt_d   = '0;
            key_d   = bus.key;
          end
        end
      end
      KEY_FWD: begin
        key_d = ks_key;
        if (cnt_q == LAST) begin
          state_d       = ROUND;
          cache_key_d   = orig_key_q;
          cache_last_d  = ks_key;
          cache_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ROUND: begin
        key_d = ks_key;
        if (!dec_q) begin
          blk_d = enc_blk;
          if (cnt_q == LAST) begin
            state_d       = DONE;
            cnt_d         = '0;
            data_out_d    = enc_blk;
            cache_key_d   = orig_key_q;
            cache_last_d  = ks_key;
            cache_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else begin
          blk_d = dec_blk;
          if (cnt_q == '0) begin
            state_d    = DONE;
            data_out_d = dec_blk;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also drops the key cache.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dec_q         <= 1'b0;
      key_q         <= '0;
      orig_key_q    <= '0;
      cache_key_q   <= '0;
      cache_last_q  <= '0;
      cache_valid_q <= 1'b0;
      blk_q         <= '0;
      data_out_q    <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dec_q         <= dec_d;
      key_q         <= key_d;
      orig_key_q    <= orig_key_d;
      cache_key_q   <= cache_key_d;
      cache_last_q  <= cache_last_d;
      cache_valid_q <= cache_valid_d;
      blk_q         <= blk_d;
      data_out_q    <= data_out_d;
      out_valid_q   <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_boron_crypt_core.sv
// Bench for boron_crypt_core: an 80-bit and a 128-bit instance driven in lockstep,
// checked against a whole-cipher reference model.
module tb_boron_crypt_core;

  localparam int ROUNDS = 25;
  localparam int SB[16]  = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
  localparam int ROT[4]  = '{0, 1, 7, 9};

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, mode, out_ready;
  logic [127:0] key_w;
  logic [63:0]  data80, data128;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  boron_crypt_core_if #(.KEY_W(80))  bus80 ();
  boron_crypt_core_if #(.KEY_W(128)) bus128 ();

  assign bus80.in_valid   = in_valid;
  assign bus80.mode       = mode;
  assign bus80.key        = key_w[79:0];
  assign bus80.data_in    = data80;
  assign bus80.out_ready  = out_ready;
  assign bus128.in_valid  = in_valid;
  assign bus128.mode      = mode;
  assign bus128.key       = key_w;
  assign bus128.data_in   = data128;
  assign bus128.out_ready = out_ready;

  boron_crypt_core #(.KEY_W(80), .ROUNDS(ROUNDS)) u_dut80 (
    .clk(clk), .reset(reset), .bus(bus80)
  );
  boron_crypt_core #(.KEY_W(128), .ROUNDS(ROUNDS)) u_dut128 (
    .clk(clk), .reset(reset), .bus(bus128)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [127:0] m_key_next(input logic [127:0] k, input int r, input int w);
    logic [127:0] t;
    t = '0;
    for (int b = 0; b < w; b++) t[(b + 13) % w] = k[b];
    t[3:0]   = 4'(SB[t[3:0]]);
    t[63:59] = t[63:59] ^ 5'(r + 1);
    return t;
  endfunction

  function automatic logic [63:0] m_rk(input logic [127:0] k, input int w);
    logic [63:0] r;
    for (int b = 0; b < 64; b++) r[b] = k[w - 64 + b];
    return r;
  endfunction

  function automatic logic [63:0] m_round(input logic [63:0] x);
    logic [63:0] s, y;
    s = x;
    for (int i = 0; i < 16; i++) s[4*i +: 4] = 4'(SB[x[4*i +: 4]]);
    y = '0;
    for (int j = 0; j < 4; j++)
      for (int b = 0; b < 16; b++) y[16*j + (b + ROT[j]) % 16] = s[16*j + b];
    return y ^ (y >> 16);
  endfunction

  function automatic logic [63:0] m_encrypt(input logic [127:0] k, input logic [63:0] p, input int w);
    logic [127:0] ks[ROUNDS+1];
    logic [63:0]  s;
    ks[0] = '0;
    for (int b = 0; b < w; b++) ks[0][b] = k[b];
    for (int r = 0; r < ROUNDS; r++) ks[r+1] = m_key_next(ks[r], r, w);
    s = p;
    for (int r = 0; r < ROUNDS; r++) s = m_round(s ^ m_rk(ks[r], w));
    return s ^ m_rk(ks[ROUNDS], w);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // hold < 0: out_ready already high before out_valid rises; hold > 0: stall that many cycles.
  task automatic run_op(input logic m, input logic [127:0] k, input logic [63:0] d80,
                        input logic [63:0] d128, input int hold,
                        output logic [63:0] o80, output logic [63:0] o128, output int lat);
    int guard;
    guard = 0;
    while (!(bus80.in_ready && bus128.in_ready) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check_eq("ready_timeout", {63'b0, bus80.in_ready}, 64'd1);
    in_valid  = 1'b1;
    mode      = m;
    key_w     = k;
    data80    = d80;
    data128   = d128;
    out_ready = (hold < 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    mode     = ~m;
    key_w    = {$urandom, $urandom, $urandom, $urandom};
    data80   = {$urandom, $urandom};
    data128  = {$urandom, $urandom};
    lat = 0;
    while (!bus80.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_eq("ov_sync", {63'b0, bus128.out_valid}, 64'd1);
    o80  = bus80.data_out;
    o128 = bus128.data_out;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (i == 2) begin
          in_valid = 1'b1;
          mode     = 1'b1;
          key_w    = k;
        end
        if (i == 5) in_valid = 1'b0;
        @(negedge clk);
        check_eq("stall_d80", bus80.data_out, o80);
        check_eq("stall_d128", bus128.data_out, o128);
        check_eq("stall_rdy", {62'b0, bus80.in_ready, bus128.in_ready}, 64'd0);
        check_eq("stall_ov", {62'b0, bus80.out_valid, bus128.out_valid}, 64'd3);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_ov", {62'b0, bus80.out_valid, bus128.out_valid}, 64'd0);
    check_eq("post_rdy", {62'b0, bus80.in_ready, bus128.in_ready}, 64'd3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0]  o80, o128, c80, c128, p;
    logic [127:0] k, k2;
    int           lat, hold, seen;

    reset = 1'b1; in_valid = 1'b0; mode = 1'b0; key_w = '0;
    data80 = '0; data128 = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check_eq("rst_rdy", {62'b0, bus80.in_ready, bus128.in_ready}, 64'd3);
    check_eq("rst_ov", {62'b0, bus80.out_valid, bus128.out_valid}, 64'd0);
    check_eq("rst_busy", {62'b0, bus80.busy, bus128.busy}, 64'd0);
    check_eq("rst_d80", bus80.data_out, 64'd0);
    check_eq("rst_d128", bus128.data_out, 64'd0);

    // Known-answer encrypt with an all-zero key.
    p   = 64'h0123_4567_89AB_CDEF;
    c80  = m_encrypt(128'd0, p, 80);
    c128 = m_encrypt(128'd0, p, 128);
    run_op(1'b0, 128'd0, p, p, 0, o80, o128, lat);
    check_eq("kat_enc80", o80, c80);
    check_eq("kat_enc128", o128, c128);
    check_eq("kat_enc_lat", 64'(lat), 64'(ROUNDS + 1));

    // Cold-cache decrypt, then a cache-hit repeat.
    do_reset();
    run_op(1'b1, 128'd0, c80, c128, 0, o80, o128, lat);
    check_eq("kat_dec80", o80, p);
    check_eq("kat_dec128", o128, p);
    check_eq("kat_dec_miss_lat", 64'(lat), 64'(2 * ROUNDS + 1));
    run_op(1'b1, 128'd0, c80, c128, -1, o80, o128, lat);
    check_eq("kat_dec80_hit", o80, p);
    check_eq("kat_dec128_hit", o128, p);
    check_eq("kat_dec_hit_lat", 64'(lat), 64'(ROUNDS + 1));

    // Consumer stall with ignored in_valid pulses.
    run_op(1'b0, 128'd0, p, p, 10, o80, o128, lat);
    check_eq("stall_enc80", o80, c80);
    check_eq("stall_enc128", o128, c128);

    // Reset during a cache-miss decrypt must abort and drop the cache.
    k  = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    p  = {$urandom, $urandom};
    run_op(1'b0, k, p, p, 0, o80, o128, lat);
    in_valid = 1'b1; mode = 1'b1; key_w = k2; data80 = o80; data128 = o128;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus80.out_valid || bus128.out_valid) seen = 1;
      @(negedge clk);
    end
    check_eq("abort_no_out", 64'(seen), 64'd0);
    check_eq("abort_d80", bus80.data_out, 64'd0);
    run_op(1'b1, k, m_encrypt(k, p, 80), m_encrypt(k, p, 128), 0, o80, o128, lat);
    check_eq("abort_dec80", o80, p);
    check_eq("abort_dec128", o128, p);
    check_eq("abort_dec_lat", 64'(lat), 64'(2 * ROUNDS + 1));

    // Randomized round trips; every fourth pair decrypts a fresh key (cache miss).
    for (int i = 0; i < 1000; i++) begin
      k    = {$urandom, $urandom, $urandom, $urandom};
      p    = {$urandom, $urandom};
      hold = int'($urandom_range(0, 2)) - 1;
      c80  = m_encrypt(k, p, 80);
      c128 = m_encrypt(k, p, 128);
      if (i % 4 != 3) begin
        run_op(1'b0, k, p, p, hold, o80, o128, lat);
        check_eq("rnd_enc80", o80, c80);
        check_eq("rnd_enc128", o128, c128);
        check_eq("rnd_enc_lat", 64'(lat), 64'(ROUNDS + 1));
        run_op(1'b1, k, o80, o128, hold, o80, o128, lat);
        check_eq("rnd_dec80", o80, p);
        check_eq("rnd_dec128", o128, p);
        check_eq("rnd_hit_lat", 64'(lat), 64'(ROUNDS + 1));
      end else begin
        run_op(1'b1, k, c80, c128, hold, o80, o128, lat);
        check_eq("rnd_mdec80", o80, p);
        check_eq("rnd_mdec128", o128, p);
        check_eq("rnd_miss_lat", 64'(lat), 64'(2 * ROUNDS + 1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/boron_crypt_core.md
BORON_CRYPT_CORE -- requirements
Module: boron_crypt_core

Interface
REQ-001 Parameter KEY_W, 80, key length in bits; only 80 and 128 legal, any other value SHALL fail elaboration.
REQ-002 Parameter ROUNDS, 25, number of cipher rounds; SHALL be 1..31.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 in_valid  input  1  request present on data_in/key/mode.
REQ-006 in_ready  output  1  core can accept a request this cycle.
REQ-007 mode  input  1  0 = encrypt, 1 = decrypt.
REQ-008 key  input  KEY_W  cipher master key.
REQ-009 data_in  input  64  plaintext (encrypt) or ciphertext (decrypt).
REQ-010 out_valid  output  1  data_out holds a finished result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 data_out  output  64  ciphertext (encrypt) or plaintext (decrypt).
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, KEY_FWD, ROUND and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept SHALL occur on a cycle where in_valid && in_ready; mode, key and data_in SHALL be sampled only at accept, and later changes SHALL have no effect.
REQ-016 Encrypt, IDLE->ROUND: SHALL perform one round per cycle, counter 0..ROUNDS-1, applying the final whitening key in the last round cycle, then enter DONE.
REQ-017 Decrypt with cache miss, IDLE->KEY_FWD: SHALL run the forward key schedule one step per cycle for ROUNDS cycles, then enter ROUND and run the inverse rounds, stepping the key schedule backward, counter ROUNDS-1 down to 0.
REQ-018 Key cache: SHALL hold cached_key (KEY_W), cached_last_key (KEY_W) and cache_valid (1).
- Update at the end of every KEY_FWD pass.
- Update at the end of every encryption, from the final round key that the encryption produced.
REQ-019 Decrypt with cache hit (cache_valid && key == cached_key): SHALL skip KEY_FWD and go IDLE->ROUND, loading cached_last_key.
REQ-020 Latency from accept edge T to first out_valid edge:
- Encrypt: T+ROUNDS+1.
- Decrypt, cache hit: T+ROUNDS+1.
- Decrypt, cache miss: T+2*ROUNDS+1.
REQ-021 DONE: out_valid SHALL be 1 and data_out SHALL be stable until out_ready is sampled 1; the FSM SHALL then go to IDLE, with in_ready=1 on the next cycle.
REQ-022 If out_ready is already 1 when out_valid rises, the transfer SHALL complete in that same cycle; back-to-back accepts SHALL therefore be spaced by at least latency+1 cycles.
REQ-023 in_valid while not in_ready SHALL be ignored, with no state change.
REQ-024 The round counter SHALL never wrap; each terminal count SHALL force the state transition.
REQ-025 out_valid SHALL be 0 in all states except DONE; data_out SHALL be a registered output.

Reset
REQ-026 On reset, state values SHALL be:
- FSM: IDLE.
- Outputs: in_ready=1, out_valid=0, busy=0, data_out=0.
- Internals: counter=0, cache_valid=0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no output produced and SHALL invalidate the key cache.

Structure
REQ-028 Package boron_pkg SHALL hold:
- The state enum.
- The 4-bit S-box and inverse S-box tables.
- The block width constant (64).
- The legal KEY_W values.
REQ-029 One sub-module, boron_key_step, SHALL be combinational, parametrised by KEY_W, and compute the next or previous round key from (key, round index, direction).
- Encrypt, KEY_FWD and ROUND SHALL share a single instance of boron_key_step.
REQ-030 The round datapath (S-box layer, block shuffle, rotation/XOR layer and inverses) SHALL be combinational functions inside boron_crypt_core.

Verification
REQ-031 KEY_W=80, encrypt data_in=0x0123456789ABCDEF with key=0x0 -> data_out equals the golden-model ciphertext; out_valid at exactly accept+26.
REQ-032 Decrypt that ciphertext with the same key after reset (cold cache) -> data_out=0x0123456789ABCDEF at accept+51; repeat the decrypt -> same value at accept+26 (cache hit).
REQ-033 KEY_W=128, 1000 random key/data pairs, encrypt then decrypt -> every round-trip returns data_in; total mismatches 0.
REQ-034 Hold out_ready=0 for 10 cycles after out_valid -> data_out stable and in_ready=0 throughout; in_valid pulses during that window are ignored.
REQ-035 Assert reset at cycle 12 of a cache-miss decrypt -> out_valid never rises; the next decrypt with the same key takes 51 cycles (cache invalidated).
